// File: rtl/cpu_loader.sv
// Streams a program into the CPU over its strobe pins, starts it, feeds runtime input bytes and counts run cycles.
// Every strobe waits on the CPU's status pins; the stream readys are high only while a byte is wanted.
module cpu_loader (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_prog_len,
    input  logic        i_prog_valid,
    input  logic [7:0]  i_prog_data,
    output logic        o_prog_ready,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic [7:0]  o_cpu_data,
    output logic        o_cpu_load_addr,
    output logic        o_cpu_load_data,
    output logic        o_cpu_execute,
    output logic        o_cpu_input_taken,
    input  logic        i_cpu_waiting,
    input  logic        i_cpu_take_input,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_cycles
);

    typedef enum logic [3:0] {
        IDLE, LD_FETCH, ADDR_SETUP, ADDR_STROBE, DATA_SETUP, DATA_STROBE,
        EXEC_SETUP, EXEC_STROBE, RUN, IN_SETUP, IN_STROBE, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [7:0]  byte_q;
    logic [7:0]  data_nxt;
    logic [8:0]  addr_inc;
    logic        in_have, in_have_nxt;
    logic        prog_xfer, in_xfer;

    assign prog_xfer   = o_prog_ready & i_prog_valid;
    assign in_xfer     = o_in_ready & i_in_valid;
    assign addr_inc    = {1'b0, addr} + 9'd1;
    // The runtime byte spends one cycle on the bus before its strobe rises.
    assign in_have_nxt = (state == IN_SETUP) && !in_have && in_xfer;

    // Setup states only advance once the bus already shows the value, so data leads every strobe.
    always_comb begin
        state_nxt = state;
        data_nxt  = o_cpu_data;
        case (state)
            IDLE, DONE: begin
                if (i_start)
                    state_nxt = (i_prog_len != 8'd0) ? LD_FETCH : EXEC_SETUP;
            end
            LD_FETCH: begin
                if (prog_xfer)
                    state_nxt = ADDR_SETUP;
            end
            ADDR_SETUP: begin
                data_nxt = addr;
                if (i_cpu_waiting && o_cpu_data == addr)
                    state_nxt = ADDR_STROBE;
            end
            ADDR_STROBE: begin
                if (!i_cpu_waiting)
                    state_nxt = DATA_SETUP;
            end
            DATA_SETUP: begin
                data_nxt = byte_q;
                if (i_cpu_take_input && !i_cpu_waiting && o_cpu_data == byte_q)
                    state_nxt = DATA_STROBE;
            end
            DATA_STROBE: begin
                if (!i_cpu_take_input)
                    state_nxt = (addr_inc < {1'b0, len}) ? LD_FETCH : EXEC_SETUP;
            end
            EXEC_SETUP: begin
                if (i_cpu_waiting)
                    state_nxt = EXEC_STROBE;
            end
            EXEC_STROBE: begin
                if (!i_cpu_waiting)
                    state_nxt = RUN;
            end
            RUN: begin
                if (i_cpu_waiting)
                    state_nxt = i_cpu_take_input ? IN_SETUP : DONE;
            end
            IN_SETUP: begin
                if (in_have)
                    state_nxt = IN_STROBE;
                else if (in_xfer)
                    data_nxt = i_in_data;
            end
            IN_STROBE: begin
                if (!i_cpu_take_input)
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            addr              <= 8'd0;
            len               <= 8'd0;
            byte_q            <= 8'd0;
            in_have           <= 1'b0;
            o_cpu_data        <= 8'd0;
            o_cycles          <= 16'd0;
            o_prog_ready      <= 1'b0;
            o_in_ready        <= 1'b0;
            o_cpu_load_addr   <= 1'b0;
            o_cpu_load_data   <= 1'b0;
            o_cpu_execute     <= 1'b0;
            o_cpu_input_taken <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            state             <= state_nxt;
            o_cpu_data        <= data_nxt;
            in_have           <= in_have_nxt;
            // Handshake outputs are decoded from the next state so they come straight off flops.
            o_prog_ready      <= (state_nxt == LD_FETCH);
            o_in_ready        <= (state_nxt == IN_SETUP) && !in_have_nxt;
            o_cpu_load_addr   <= (state_nxt == ADDR_STROBE);
            o_cpu_load_data   <= (state_nxt == DATA_STROBE);
            o_cpu_execute     <= (state_nxt == EXEC_STROBE);
            o_cpu_input_taken <= (state_nxt == IN_STROBE);
            o_busy            <= !(state_nxt inside {IDLE, DONE});
            o_done            <= (state_nxt == DONE);
            if ((state == IDLE || state == DONE) && i_start) begin
                len      <= i_prog_len;
                addr     <= 8'd0;
                o_cycles <= 16'd0;
            end
            if (prog_xfer)
                byte_q <= i_prog_data;
            if (state == DATA_STROBE && !i_cpu_take_input)
                addr <= addr + 8'd1;
            if (state == RUN && o_cycles != 16'hFFFF)
                o_cycles <= o_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Randomized bench for cpu_loader with a behavioural CPU, stream sources and a strobe/bus protocol monitor.
module tb_cpu_loader;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_prog_len;
    logic        i_prog_valid;
    logic [7:0]  i_prog_data;
    logic        o_prog_ready;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        o_in_ready;
    logic [7:0]  o_cpu_data;
    logic        o_cpu_load_addr;
    logic        o_cpu_load_data;
    logic        o_cpu_execute;
    logic        o_cpu_input_taken;
    logic        i_cpu_waiting;
    logic        i_cpu_take_input;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_cycles;

    always #5 i_clk = ~i_clk;

    cpu_loader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_prog_len(i_prog_len),
        .i_prog_valid(i_prog_valid), .i_prog_data(i_prog_data), .o_prog_ready(o_prog_ready),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_cpu_data(o_cpu_data), .o_cpu_load_addr(o_cpu_load_addr), .o_cpu_load_data(o_cpu_load_data),
        .o_cpu_execute(o_cpu_execute), .o_cpu_input_taken(o_cpu_input_taken),
        .i_cpu_waiting(i_cpu_waiting), .i_cpu_take_input(i_cpu_take_input),
        .o_busy(o_busy), .o_done(o_done), .o_cycles(o_cycles)
    );

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Stimulus queues and observation logs shared with the helper processes
    logic [7:0] prog_q[$];
    logic [7:0] in_q[$];
    int         in_dly[$];
    int         plan[$];          // run lengths between CPU input requests; the last one ends in a halt
    logic [7:0] addr_log[$];
    logic [7:0] got_in[$];
    int         in_runs[$];
    logic [7:0] ram[256];
    int exec_cnt, data_cnt, prdy_cnt, viol;

    // Behavioural CPU: answers each strobe on the following cycle and runs for the planned cycle counts.
    initial begin
        int cph, rem;
        logic [7:0] cpu_addr;
        i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b0; cph = 0; rem = 0; cpu_addr = 8'd0;
        forever begin
            @(posedge i_clk); #1;
            if (i_reset) begin
                cph = 0; i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b0; plan.delete();
            end else begin
                case (cph)
                    0: if (o_cpu_load_addr) begin
                           cpu_addr = o_cpu_data; addr_log.push_back(o_cpu_data);
                           i_cpu_waiting = 1'b0; i_cpu_take_input = 1'b1; cph = 1;
                       end else if (o_cpu_execute) begin
                           exec_cnt++; rem = (plan.size() > 0) ? plan.pop_front() : 1;
                           i_cpu_waiting = 1'b0; cph = 2;
                       end
                    1: if (o_cpu_load_data) begin
                           ram[cpu_addr] = o_cpu_data; data_cnt++;
                           i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b0; cph = 0;
                       end
                    2: begin
                           rem--;
                           if (rem <= 0) begin
                               i_cpu_waiting = 1'b1;
                               i_cpu_take_input = (plan.size() > 0);
                               cph = (plan.size() > 0) ? 3 : 0;
                           end
                       end
                    3: if (o_cpu_input_taken) begin
                           got_in.push_back(o_cpu_data); rem = plan.pop_front();
                           i_cpu_waiting = 1'b0; i_cpu_take_input = 1'b0; cph = 2;
                       end
                    default: cph = 0;
                endcase
            end
        end
    end

    // Program byte source with random gaps; valid may be raised while ready is low.
    initial begin
        bit x;
        i_prog_valid = 1'b0; i_prog_data = 8'd0;
        forever begin
            @(negedge i_clk); x = i_prog_valid && o_prog_ready;
            @(posedge i_clk); #1;
            if (x && prog_q.size() > 0) begin void'(prog_q.pop_front()); i_prog_valid = 1'b0; end
            if (prog_q.size() == 0) i_prog_valid = 1'b0;
            else if (!i_prog_valid && $urandom_range(0, 2) != 0) begin
                i_prog_valid = 1'b1; i_prog_data = prog_q[0];
            end
        end
    end

    // Runtime input source: offers the next byte after ready has been seen high for its delay.
    initial begin
        bit x;
        int in_wait;
        i_in_valid = 1'b0; i_in_data = 8'd0; in_wait = 0;
        forever begin
            @(negedge i_clk); x = i_in_valid && o_in_ready;
            @(posedge i_clk); #1;
            if (x) begin
                void'(in_q.pop_front()); void'(in_dly.pop_front()); i_in_valid = 1'b0; in_wait = 0;
            end else if (!i_in_valid && in_q.size() > 0 && o_in_ready) begin
                if (in_wait >= in_dly[0]) begin i_in_valid = 1'b1; i_in_data = in_q[0]; end
                else in_wait++;
            end
        end
    end

    // Monitor: one strobe at a time, bus unchanged on the cycle a strobe rises, while high and after it falls.
    initial begin
        logic [3:0] s, prev_s;
        logic [7:0] prev_d;
        bit prev_rst;
        int in_run;
        prev_s = 4'd0; prev_d = 8'd0; prev_rst = 1'b1; in_run = 0;
        forever begin
            @(negedge i_clk);
            s = {o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken};
            if (o_prog_ready) prdy_cnt++;
            if (o_in_ready) in_run++;
            else if (in_run > 0) begin in_runs.push_back(in_run); in_run = 0; end
            if (!i_reset && !prev_rst) begin
                if ($countones(s) > 1) viol++;
                if ((s != 4'd0 || prev_s != 4'd0) && o_cpu_data !== prev_d) viol++;
            end
            prev_s = s; prev_d = o_cpu_data; prev_rst = i_reset;
        end
    end

    task automatic run_prog(input string tag, input bit glitch);
        logic [7:0] exp_bytes[$];
        logic [7:0] exp_in[$];
        int exp_dly[$];
        int exp_cyc, len, budget, c;
        exp_bytes = prog_q; exp_in = in_q; exp_dly = in_dly;
        len = prog_q.size();
        exp_cyc = 0;
        foreach (plan[i]) exp_cyc += plan[i];
        budget = exp_cyc + 3000;
        if (exp_cyc > 65535) exp_cyc = 65535;
        addr_log.delete(); got_in.delete(); in_runs.delete();
        exec_cnt = 0; data_cnt = 0; prdy_cnt = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'hxx;
        @(posedge i_clk); #1;
        i_prog_len = 8'(len); i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check({tag, "_cycles_cleared"}, o_cycles, 0);
        check({tag, "_busy_after_start"}, o_busy, 1);
        check({tag, "_done_cleared"}, o_done, 0);
        c = 0;
        while (!o_done && c < budget) begin
            // A start while busy must be ignored (different length too).
            i_start = glitch && (c == 20);
            if (glitch && c == 20) i_prog_len = 8'd9;
            @(posedge i_clk); #1;
            c++;
        end
        i_start = 1'b0;
        check({tag, "_done"}, o_done, 1);
        check({tag, "_busy_at_done"}, o_busy, 0);
        check({tag, "_cycles"}, o_cycles, exp_cyc);
        check({tag, "_addr_handshakes"}, addr_log.size(), len);
        check({tag, "_data_handshakes"}, data_cnt, len);
        check({tag, "_exec_handshakes"}, exec_cnt, 1);
        foreach (exp_bytes[i]) begin
            check($sformatf("%s_addr%0d", tag, i), (i < addr_log.size()) ? addr_log[i] : 32'hDEAD, i);
            check($sformatf("%s_ram%0d", tag, i), ram[i], exp_bytes[i]);
        end
        check({tag, "_inputs"}, got_in.size(), exp_in.size());
        foreach (exp_in[i]) begin
            check($sformatf("%s_in%0d", tag, i), (i < got_in.size()) ? got_in[i] : 32'hDEAD, exp_in[i]);
            // ready stays up through the whole delay plus the accepting cycle
            check($sformatf("%s_inrdy%0d", tag, i), (i < in_runs.size()) ? in_runs[i] : -1, exp_dly[i] + 1);
        end
        if (len == 0) check({tag, "_no_prog_ready"}, prdy_cnt, 0);
    endtask

    initial begin
        int c, remaining, nseg;
        viol = 0; exec_cnt = 0; data_cnt = 0; prdy_cnt = 0;
        i_reset = 1'b1; i_start = 1'b0; i_prog_len = 8'd0;
        #3;
        check("rst_prog_ready", o_prog_ready, 0);
        check("rst_in_ready", o_in_ready, 0);
        check("rst_strobes", {o_cpu_load_addr, o_cpu_load_data, o_cpu_execute, o_cpu_input_taken}, 0);
        check("rst_busy_done", {o_busy, o_done}, 0);
        check("rst_cpu_data", o_cpu_data, 0);
        check("rst_cycles", o_cycles, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("idle_busy_done", {o_busy, o_done}, 0);

        prog_q = '{8'h06, 8'h00, 8'h2A}; plan = '{5};
        run_prog("load3", 1'b0);

        plan = '{8};
        run_prog("exec_only", 1'b0);

        prog_q = '{8'($urandom), 8'($urandom)}; plan = '{15, 22};
        in_q = '{8'h5A}; in_dly = '{10};
        run_prog("input5a", 1'b1);

        plan = '{37};
        run_prog("restart37", 1'b0);

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 12)) prog_q.push_back(8'($urandom));
            nseg = $urandom_range(1, 3);
            for (int k = 0; k < nseg; k++) begin
                plan.push_back($urandom_range(1, 40));
                if (k > 0) begin in_q.push_back(8'($urandom)); in_dly.push_back($urandom_range(0, 6)); end
            end
            run_prog($sformatf("rand%0d", r), 1'b0);
        end

        prog_q = '{8'h11, 8'h22, 8'h33, 8'h44}; plan = '{10};
        @(posedge i_clk); #1;
        i_prog_len = 8'd4; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        c = 0;
        while (!o_cpu_load_data && c < 500) begin @(posedge i_clk); #1; c++; end
        check("rst_mid_strobe_reached", o_cpu_load_data, 1);
        #2;
        i_reset = 1'b1;
        #1;
        check("rst_mid_strobe_drop", o_cpu_load_data, 0);
        check("rst_mid_busy_done", {o_busy, o_done}, 0);
        check("rst_mid_cpu_data", o_cpu_data, 0);
        check("rst_mid_prog_ready", o_prog_ready, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        remaining = prog_q.size();
        prdy_cnt = 0;
        repeat (20) @(posedge i_clk);
        #1;
        check("rst_no_rerequest", prdy_cnt, 0);
        check("rst_no_consume", prog_q.size(), remaining);
        check("rst_stays_idle", o_busy, 0);
        prog_q.delete(); plan.delete();
        repeat (3) @(posedge i_clk);

        prog_q = '{8'h77}; plan = '{70000};
        run_prog("saturate", 1'b0);

        check("strobe_protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
